// File: rtl/ltc23xx_pkg.sv
// Shared definitions for the LTC23xx conversion sequencer.
// Holds the FSM encoding, the SDI control-word layout and the default timing.
package ltc23xx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_CONVERT   = 3'd1;
    localparam state_t S_WAIT_CONV = 3'd2;
    localparam state_t S_SHIFT     = 3'd3;
    localparam state_t S_GAP       = 3'd4;

    // Control word: {start=1, 0, chan[2:0], range[2:0]}, shifted MSB first
    localparam int CW_LEN       = 8;
    localparam int CW_START_BIT = 7;
    localparam int CW_CHAN_LSB  = 3;
    localparam int CW_RANGE_LSB = 0;

    localparam int DEF_BUSY_CYCLES = 28;
    localparam int DEF_SLOT_BITS   = 24;

    function automatic logic [CW_LEN-1:0] ctrl_word(input logic [2:0] chan,
                                                    input logic [2:0] rng);
        ctrl_word = '0;
        ctrl_word[CW_START_BIT]         = 1'b1;
        ctrl_word[CW_CHAN_LSB +: 3]     = chan;
        ctrl_word[CW_RANGE_LSB +: 3]    = rng;
    endfunction

endpackage

// File: rtl/ltc23xx_next_chan.sv
// Finds the lowest set bit of the channel mask and the next set bit above
// the current channel index.
module ltc23xx_next_chan #(
    parameter int NCHAN = 8,
    parameter int CHW   = $clog2(NCHAN)
) (
    input  logic [NCHAN-1:0] mask,
    input  logic [CHW-1:0]   cur,
    output logic [CHW-1:0]   first,
    output logic [CHW-1:0]   next,
    output logic             has_next
);

    // Descending scan: the last hit written is the lowest qualifying index
    always_comb begin
        first    = '0;
        next     = '0;
        has_next = 1'b0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = CHW'(i);
                if (i > int'(cur)) begin
                    next     = CHW'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ltc23xx_seq_ctrl.sv
// Frame sequencer for an LTC23xx SAR ADC: CNV strobe, conversion wait,
// per-channel SCKI/SDI readout and a one-deep sample output register.
module ltc23xx_seq_ctrl
    import ltc23xx_pkg::*;
#(
    parameter int NCHAN        = 8,
    parameter int SLOT_BITS    = DEF_SLOT_BITS,
    parameter int CTRL_BITS    = 8,
    parameter int BUSY_CYCLES  = DEF_BUSY_CYCLES,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cfg_mode,
    input  logic [15:0]              cfg_n_reads,
    input  logic [NCHAN-1:0]         cfg_active,
    input  logic [3*NCHAN-1:0]       cfg_range,
    input  logic [31:0]              cfg_period,
    input  logic                     cfg_use_busy,
    input  logic                     busy,
    input  logic                     sdo,
    output logic                     cnv,
    output logic                     sdi,
    output logic                     scki_en,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [SLOT_BITS-1:0]     m_data,
    output logic [$clog2(NCHAN)-1:0] m_chan,
    output logic                     running,
    output logic                     done,
    output logic                     overflow,
    output logic                     err
);

    localparam int CHW   = $clog2(NCHAN);
    localparam int BITW  = $clog2(SLOT_BITS);
    localparam int WMAX  = (BUSY_CYCLES > BUSY_TIMEOUT) ? BUSY_CYCLES : BUSY_TIMEOUT;
    localparam int WAITW = $clog2(WMAX + 1);

    state_t               state;
    logic [31:0]          per_cnt;
    logic [15:0]          rem;
    logic [WAITW-1:0]     wait_cnt;
    logic [BITW-1:0]      bit_cnt;
    logic [CHW-1:0]       chan;
    logic [SLOT_BITS-1:0] shreg;
    logic                 stop_req;

    logic                 mode_q;
    logic                 busy_mode_q;
    logic [NCHAN-1:0]     act_q;
    logic [3*NCHAN-1:0]   rng_q;
    logic [31:0]          per_q;

    logic [CHW-1:0]       first_chan;
    logic [CHW-1:0]       next_chan;
    logic                 has_next;

    logic                 start_ok;
    logic                 start_go;
    logic                 gap_end;
    logic                 finish;
    logic                 load_cfg;
    logic [32:0]          per_next;
    logic [SLOT_BITS-1:0] word;
    logic [CW_LEN-1:0]    cw;
    logic [CW_LEN-1:0]    cw_sh;

    ltc23xx_next_chan #(.NCHAN(NCHAN), .CHW(CHW)) u_next_chan (
        .mask     (act_q),
        .cur      (chan),
        .first    (first_chan),
        .next     (next_chan),
        .has_next (has_next)
    );

    always_comb begin
        start_ok = (cfg_active != '0) && (cfg_mode || cfg_n_reads != 16'd0);
        start_go = (state == S_IDLE) && start && start_ok;
        per_next = {1'b0, per_cnt} + 33'd1;
        gap_end  = per_next >= {1'b0, per_q};
        finish   = stop_req || stop || (!mode_q && rem == 16'd0);
        load_cfg = start_go || ((state == S_GAP) && gap_end && !finish);
        word     = {shreg[SLOT_BITS-2:0], sdo};
        cw       = ctrl_word(3'(chan), rng_q[3*chan +: 3]);
        cw_sh    = cw << bit_cnt;
    end

    assign cnv     = (state == S_CONVERT);
    assign scki_en = (state == S_SHIFT);
    assign sdi     = (state == S_SHIFT) && (32'(bit_cnt) < CTRL_BITS) ? cw_sh[CW_LEN-1] : 1'b0;
    assign running = (state != S_IDLE);

    // Frame configuration is frozen at each frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= 1'b0;
            busy_mode_q <= 1'b0;
            act_q       <= '0;
            rng_q       <= '0;
            per_q       <= '0;
        end else if (load_cfg) begin
            mode_q      <= cfg_mode;
            busy_mode_q <= cfg_use_busy;
            act_q       <= cfg_active;
            rng_q       <= cfg_range;
            per_q       <= cfg_period;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            per_cnt  <= '0;
            rem      <= '0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            chan     <= '0;
            shreg    <= '0;
            stop_req <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_chan   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && per_cnt != '1) per_cnt <= per_cnt + 32'd1;
            if (state != S_IDLE && stop) stop_req <= 1'b1;
            if (m_ready) m_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    per_cnt  <= '0;
                    stop_req <= 1'b0;
                    if (start) begin
                        overflow <= 1'b0;
                        err      <= 1'b0;
                        if (start_ok) begin
                            rem   <= cfg_n_reads;
                            state <= S_CONVERT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_CONVERT: begin
                    per_cnt  <= 32'd1;
                    wait_cnt <= '0;
                    if (!mode_q && rem != 16'd0) rem <= rem - 16'd1;
                    state <= S_WAIT_CONV;
                end
                S_WAIT_CONV: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (busy_mode_q) begin
                        if (!busy) begin
                            state   <= S_SHIFT;
                            bit_cnt <= '0;
                            chan    <= first_chan;
                        end else if (wait_cnt == WAITW'(BUSY_TIMEOUT - 1)) begin
                            err     <= 1'b1;
                            state   <= S_SHIFT;
                            bit_cnt <= '0;
                            chan    <= first_chan;
                        end
                    end else if (wait_cnt == WAITW'(BUSY_CYCLES - 1)) begin
                        state   <= S_SHIFT;
                        bit_cnt <= '0;
                        chan    <= first_chan;
                    end
                end
                S_SHIFT: begin
                    shreg <= word;
                    if (bit_cnt == BITW'(SLOT_BITS - 1)) begin
                        bit_cnt <= '0;
                        // A word still waiting for the consumer wins over the new one
                        if (!m_valid || m_ready) begin
                            m_data  <= word;
                            m_chan  <= chan;
                            m_valid <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (has_next) chan <= next_chan;
                        else          state <= S_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if ({1'b0, per_cnt} >= {1'b0, per_q}) err <= 1'b1;
                    if (gap_end) begin
                        if (finish) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CONVERT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc23xx_seq_ctrl.sv
// Self-checking bench for ltc23xx_seq_ctrl: ADC model on SCKI, scoreboard of
// expected samples and SDI control words, frame timing checks.
module tb_ltc23xx_seq_ctrl;

    typedef struct packed {
        logic [2:0]  chan;
        logic [23:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic        cfg_mode = 1'b0;
    logic [15:0] cfg_n_reads = '0;
    logic [7:0]  cfg_active = '0;
    logic [23:0] cfg_range = '0;
    logic [31:0] cfg_period = '0;
    logic        cfg_use_busy = 1'b0;
    logic        busy = 1'b0, sdo = 1'b0;
    logic        cnv, sdi, scki_en, m_valid, running, done, overflow, err;
    logic        m_ready = 1'b1;
    logic [23:0] m_data;
    logic [2:0]  m_chan;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    exp_t        exp_q[$];
    logic [23:0] sdi_q[$];
    logic        fixed_en = 1'b0;
    logic [23:0] fixed_pat = '0;

    int cnv_cnt = 0, cnv_last = 0, cnv_prev = 0;
    int done_cnt = 0, done_cyc = 0;
    int scki_cnt = 0, first_scki = 0;
    logic scki_prev = 1'b0;
    int b = 0, adc_slot = 0;
    logic [23:0] adc_w = '0, sdi_sh = '0;

    ltc23xx_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_n_reads(cfg_n_reads), .cfg_active(cfg_active),
        .cfg_range(cfg_range), .cfg_period(cfg_period), .cfg_use_busy(cfg_use_busy),
        .busy(busy), .sdo(sdo), .cnv(cnv), .sdi(sdi), .scki_en(scki_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
        .running(running), .done(done), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] data_fn(input int n);
        return 24'hC35A96 ^ {8'(n), 8'(n * 3 + 1), 8'(n * 7 + 2)};
    endfunction

    // ADC model and output monitors, all sampled on the falling edge
    always @(negedge clk) begin
        if (reset || !scki_en) begin
            b   = 0;
            sdo = 1'b0;
        end else begin
            if (b == 0) adc_w = fixed_en ? fixed_pat : data_fn(adc_slot);
            sdo    = adc_w[23 - b];
            sdi_sh = {sdi_sh[22:0], sdi};
            scki_cnt++;
            b++;
            if (b == 24) begin
                b = 0;
                adc_slot++;
                if (sdi_q.size() == 0) chk("sdi_unexpected_slot", sdi_q.size(), 1);
                else chk("sdi_word", sdi_sh, sdi_q.pop_front());
            end
        end
        if (scki_en && !scki_prev) first_scki = cyc;
        scki_prev = scki_en;
        if (cnv) begin
            cnv_cnt++;
            cnv_prev = cnv_last;
            cnv_last = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("m_data", m_data, e.data);
                chk("m_chan", m_chan, e.chan);
            end
        end
    end

    task automatic set_cfg(input logic mode, input logic [15:0] n, input logic [7:0] act,
                           input logic [23:0] rng, input logic [31:0] per, input logic ub);
        cfg_mode = mode; cfg_n_reads = n; cfg_active = act;
        cfg_range = rng; cfg_period = per; cfg_use_busy = ub;
    endtask

    task automatic push_exp(input int frames, input int keep);
        int k = 0;
        for (int f = 0; f < frames; f++)
            for (int ch = 0; ch < 8; ch++)
                if (cfg_active[ch]) begin
                    if (f < keep)
                        exp_q.push_back('{3'(ch), fixed_en ? fixed_pat : data_fn(adc_slot + k)});
                    sdi_q.push_back({1'b1, 1'b0, 3'(ch), cfg_range[3*ch +: 3], 16'h0});
                    k++;
                end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, done_cnt - d0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_scki(input int budget);
        int n = 0;
        while (!scki_en && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scki_seen", scki_en, 1);
    endtask

    initial begin
        int c0, s0, d0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {cnv, sdi, scki_en, m_valid, running, done, overflow, err}, 8'h00);
        chk("rst_data", {m_data, m_chan}, 27'h0);
        reset = 1'b0;

        // Two-channel counted run, timed conversion
        set_cfg(1'b0, 16'd2, 8'h81, 24'h0 | 24'd5 | (24'd2 << 21), 32'd200, 1'b0);
        c0 = cnv_cnt; s0 = scki_cnt;
        push_exp(2, 2);
        pulse_start();
        wait_done(1000, "t1_done");
        chk("t1_cnv_count", cnv_cnt - c0, 2);
        chk("t1_cnv_spacing", cnv_last - cnv_prev, 200);
        chk("t1_done_after_gap", done_cyc - cnv_last, 200);
        chk("t1_conv_wait", first_scki - cnv_last, 29);
        chk("t1_scki_cycles", scki_cnt - s0, 96);
        chk("t1_flags", {running, overflow, err}, 3'b000);

        // Fixed pattern on channel 3 only
        fixed_en = 1'b1; fixed_pat = 24'hA5A5A5;
        set_cfg(1'b0, 16'd1, 8'h08, 24'h0, 32'd100, 1'b0);
        s0 = scki_cnt;
        push_exp(1, 1);
        pulse_start();
        wait_done(500, "t2_done");
        chk("t2_scki_cycles", scki_cnt - s0, 24);
        fixed_en = 1'b0;

        // Consumer stalled across two frames: second word dropped
        m_ready = 1'b0;
        set_cfg(1'b0, 16'd2, 8'h02, 24'h0 | (24'd3 << 3), 32'd80, 1'b0);
        push_exp(2, 1);
        pulse_start();
        wait_done(500, "t3_done");
        chk("t3_held", {m_valid, overflow}, 2'b11);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_drained", {exp_q.size() == 0, m_valid}, 2'b10);

        // Rejected starts: done pulses, sticky flags cleared, nothing runs
        set_cfg(1'b0, 16'd0, 8'h01, 24'h0, 32'd80, 1'b0);
        c0 = cnv_cnt;
        pulse_start();
        wait_done(5, "t4_rej_count_done");
        chk("t4_ovf_cleared", overflow, 0);
        set_cfg(1'b1, 16'd4, 8'h00, 24'h0, 32'd80, 1'b0);
        pulse_start();
        wait_done(5, "t4_rej_mask_done");
        chk("t4_no_cnv", cnv_cnt - c0, 0);
        chk("t4_idle", running, 0);

        // Busy stuck high: timeout sets err, readout still happens
        busy = 1'b1;
        set_cfg(1'b0, 16'd1, 8'h01, 24'd7, 32'd200, 1'b1);
        s0 = scki_cnt;
        push_exp(1, 1);
        pulse_start();
        wait_done(500, "t5_done");
        chk("t5_timeout_wait", first_scki - cnv_last, 65);
        chk("t5_err", err, 1);
        chk("t5_scki_cycles", scki_cnt - s0, 24);
        busy = 1'b0;

        // Period shorter than the frame: err and a single GAP cycle
        set_cfg(1'b0, 16'd2, 8'h01, 24'd1, 32'd20, 1'b0);
        push_exp(2, 2);
        pulse_start();
        #1 chk("t6_err_cleared", err, 0);
        wait_done(500, "t6_done");
        chk("t6_spacing", cnv_last - cnv_prev, 54);
        chk("t6_done_after_gap", done_cyc - cnv_last, 54);
        chk("t6_err", err, 1);

        // Continuous run stopped mid-SHIFT: frame completes
        set_cfg(1'b1, 16'd0, 8'h01, 24'd2, 32'd100, 1'b0);
        c0 = cnv_cnt;
        push_exp(1, 1);
        pulse_start();
        wait_scki(100);
        repeat (3) @(posedge clk);
        pulse_stop();
        wait_done(500, "t7_done");
        chk("t7_cnv_count", cnv_cnt - c0, 1);
        chk("t7_done_after_gap", done_cyc - cnv_last, 100);
        chk("t7_idle", running, 0);

        // Reset mid-SHIFT aborts with no word and no done
        set_cfg(1'b1, 16'd0, 8'h01, 24'd4, 32'd100, 1'b0);
        sdi_q.delete();
        pulse_start();
        wait_scki(100);
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("t8_rst_outs", {cnv, sdi, scki_en, m_valid, running, done, overflow, err}, 8'h00);
        chk("t8_rst_data", {m_data, m_chan}, 27'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t8_no_done", done_cnt - d0, 0);
        chk("t8_no_word", {m_valid, running}, 2'b00);

        chk("queues_empty", exp_q.size() + sdi_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ltc23xx_seq_ctrl.md
LTC23XX_SEQ_CTRL -- requirements
Module: ltc23xx_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): NCHAN 8 channel count; SLOT_BITS 24 SCKI cycles per channel readout; CTRL_BITS 8 SDI control-word length; BUSY_CYCLES 28 fixed conversion wait; BUSY_TIMEOUT 64 max wait for busy in busy mode.
REQ-002 Ports, one per line: name, direction, width, meaning.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a run from IDLE.
REQ-006 stop  in  1  one-cycle pulse; ends the run at the next frame boundary.
REQ-007 cfg_mode  in  1  0 = counted run, 1 = continuous run.
REQ-008 cfg_n_reads  in  16  frames per counted run.
REQ-009 cfg_active  in  NCHAN  active-channel mask.
REQ-010 cfg_range  in  3*NCHAN  per-channel SoftSpan code; channel k uses bits [3k+2:3k].
REQ-011 cfg_period  in  32  CNV-to-CNV spacing in clk cycles.
REQ-012 cfg_use_busy  in  1  1 = end conversion on busy falling; 0 = wait BUSY_CYCLES.
REQ-013 busy, sdo  in  1 each  ADC busy and serial data out.
REQ-014 cnv, sdi, scki_en  out  1 each  convert strobe, serial control data, SCKI gate (scki = scki_en & ~clk, built outside this module).
REQ-015 m_valid/m_ready  out/in  1 each  sample-output handshake.
REQ-016 m_data, m_chan  out  SLOT_BITS, $clog2(NCHAN)  captured slot and its channel index.
REQ-017 running, done, overflow, err  out  1 each  run active; one-cycle end-of-run pulse; sticky dropped-sample flag; sticky busy-timeout/period-short flag.

Function
REQ-018 States: IDLE, CONVERT, WAIT_CONV, SHIFT, GAP.
REQ-019 IDLE->CONVERT on start when cfg_active!=0 and (cfg_mode=1 or cfg_n_reads!=0); otherwise start is ignored and done pulses for one cycle.
REQ-020 Config is snapshotted on every IDLE->CONVERT and GAP->CONVERT transition; changes are ignored within a frame.
REQ-021 CONVERT lasts 1 cycle with cnv=1; the next state is WAIT_CONV.
REQ-022 WAIT_CONV, busy mode: after at least 1 cycle, exit on busy=0; if BUSY_TIMEOUT cycles elapse, set err and exit anyway.
REQ-023 WAIT_CONV, timed mode: exit after exactly BUSY_CYCLES cycles.
REQ-024 SHIFT: scki_en=1 for SLOT_BITS cycles per active channel, channels visited in ascending index order starting at the lowest set bit of cfg_active.
REQ-025 SDI per slot: control word {1,0,chan[2:0],range[2:0]}, MSB first, in the first CTRL_BITS cycles, then 0; for NCHAN>8, chan takes the low 3 bits of the index.
REQ-026 sdo is shifted in MSB first on every SHIFT cycle; at the last slot cycle the word plus channel index go to the output register.
REQ-027 Output register: if m_valid=0 or m_ready=1, load and set m_valid=1; otherwise drop the new word and set overflow; m_valid clears on m_ready without a new load.
REQ-028 GAP: hold cnv=0 and scki_en=0 until cfg_period cycles have elapsed since the CONVERT cycle, then go to CONVERT.
REQ-029 If the frame length is at least cfg_period, set err and go to CONVERT after 1 GAP cycle.
REQ-030 Counted mode: decrement the remaining count at each CONVERT; at end of GAP with count 0, go to IDLE and pulse done.
REQ-031 stop, or count exhaustion, is honoured only at end of GAP (a frame is never truncated); go to IDLE and pulse done.
REQ-032 start while not in IDLE is ignored; start in IDLE clears overflow and err.
REQ-033 Counters are 32-bit for the period, 16-bit for reads, $clog2 widths for slot and channel; no wrap is permitted inside a frame.

Reset
REQ-034 On reset, the next edge gives: state IDLE; cnv, sdi, scki_en, m_valid, running, done, overflow, err = 0; m_data and m_chan = 0; all counters = 0.
REQ-035 Reset mid-frame aborts immediately with no output word and no done pulse.

Structure
REQ-036 Shared package ltc23xx_pkg holds state_t, the control-word field layout, and default BUSY_CYCLES/SLOT_BITS constants.
REQ-037 One sub-module, ltc23xx_next_chan: combinational next active channel and first active channel from the mask and current index.

Verification
REQ-038 cfg_active=0x81, cfg_mode=0, cfg_n_reads=2, cfg_period=200, timed mode -> 2 CNV pulses 200 cycles apart; 4 words with chan 0,7,0,7; SDI words 0x80|range0 and 0xB8|range7; done 1 cycle after the 2nd GAP.
REQ-039 sdo driven with pattern 0xA5A5A5 for channel 3 only -> m_data=0xA5A5A5, m_chan=3; 24 scki_en cycles per frame.
REQ-040 m_ready held 0 across 2 frames with 1 channel -> first word kept, overflow=1, second word dropped.
REQ-041 cfg_use_busy=1 with busy stuck high -> err=1 after 64 cycles, then SHIFT proceeds.
REQ-042 cfg_mode=1, stop asserted mid-SHIFT -> frame completes, done pulses after GAP, state IDLE.
REQ-043 reset asserted mid-SHIFT -> all outputs 0 at the next edge, no m_valid, no done.
